fc_control_gen: RTL

Parametrised controller for one fully-connected layer. It generalises the fixed four-bank FC controller to any bank count PI, with configurable fan-in/fan-out and explicit memory read and multiplier latencies. It sequences input-neuron and weight reads (two neurons per beat, on ports a/b) and muxes the active bank onto the MAC datapath. It drives accumulate-load, multiply-enable and write strobes, and adds a start/busy/done handshake and an issue stall. It sits between the FC input-neuron bank memories, the weight memory and the PO-wide MAC array.

---
 rtl/fc_gen_pkg.sv | 50 +++++
 rtl/fc_delay_line.sv | 27 ++
 rtl/fc_control_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fc_gen_pkg.sv
// Shared definitions for the parametrised FC-layer controller: state encoding,
// derived-size helpers and the legality check on the layer geometry.
package fc_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } fc_state_e;

  // Ceiling log2, never narrower than one bit so every derived bus stays legal.
  function automatic int fc_clog2(input int value);
    int width;
    int pow;
    width = 32'sd1;
    pow   = 32'sd2;
    while (pow < value) begin
      pow   = pow * 32'sd2;
      width = width + 32'sd1;
    end
    return width;
  endfunction

  function automatic int fc_steps(input int inneuron);
    return inneuron / 32'sd2;
  endfunction

  function automatic int fc_bpb(input int inneuron, input int pi);
    return (pi > 32'sd0) ? (inneuron / 32'sd2) / pi : 32'sd1;
  endfunction

  function automatic int fc_groups(input int outneuron, input int po);
    return (po > 32'sd0) ? outneuron / po : 32'sd1;
  endfunction

  function automatic bit fc_params_legal(input int pi, input int inneuron, input int outneuron,
                                         input int po, input int rd_lat, input int mult_lat);
    if (pi < 32'sd1 || po < 32'sd1 || rd_lat < 32'sd1 || mult_lat < 32'sd1) begin
      return 1'b0;
    end else if (inneuron < 32'sd2 || (inneuron % 32'sd2) != 32'sd0) begin
      return 1'b0;
    end else if (((inneuron / 32'sd2) % pi) != 32'sd0) begin
      return 1'b0;
    end else begin
      return (outneuron >= po) && ((outneuron % po) == 32'sd0);
    end
  endfunction

endpackage

// File: rtl/fc_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns control words with
// memory read latency and with the multiplier/accumulator latency.
module fc_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; a clear empties all stages at once
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= {WIDTH{1'b0}};
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fc_control_gen.sv
// Controller for one fully-connected layer: issues neuron/weight reads two
// neurons per beat, muxes the active bank onto the MAC and strobes group writes.
module fc_control_gen
  import fc_gen_pkg::*;
#(
  parameter int DATA_WIDTH_FC = 16,
  parameter int PI            = 4,
  parameter int INNEURON      = 120,
  parameter int OUTNEURON     = 84,
  parameter int PO            = 2,
  parameter int RD_LAT        = 1,
  parameter int MULT_LAT      = 2,
  localparam int STEPS        = fc_steps(INNEURON),
  localparam int BPB          = fc_bpb(INNEURON, PI),
  localparam int GROUPS       = fc_groups(OUTNEURON, PO),
  localparam int CNT_W        = fc_clog2(STEPS),
  localparam int GRP_W        = fc_clog2(GROUPS + 1),
  localparam int IN_ADDR_W    = fc_clog2(2 * BPB),
  localparam int W_ADDR_W     = fc_clog2(GROUPS * STEPS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stall,
  input  logic [DATA_WIDTH_FC*PI-1:0] in_neuron_q_a_all,
  input  logic [DATA_WIDTH_FC*PI-1:0] in_neuron_q_b_all,
  output logic                        in_neuron_rden,
  output logic [IN_ADDR_W-1:0]        in_neuron_addr_a,
  output logic [IN_ADDR_W-1:0]        in_neuron_addr_b,
  output logic                        fc_weight_rden,
  output logic [W_ADDR_W-1:0]         fc_weight_addr,
  output logic [DATA_WIDTH_FC-1:0]    in_neuron_q_a_mux,
  output logic [DATA_WIDTH_FC-1:0]    in_neuron_q_b_mux,
  output logic                        accum_sload,
  output logic                        enable_mult,
  output logic                        write_en,
  output logic [GRP_W-1:0]            out_addr,
  output logic [CNT_W-1:0]            count_sload,
  output logic [GRP_W-1:0]            count_out,
  output logic                        busy,
  output logic                        done
);

  localparam int BANK_W = fc_clog2(PI);
  localparam int META_W = 3 + BANK_W + GRP_W;
  localparam int WR_W   = 1 + GRP_W;

  if (!fc_params_legal(PI, INNEURON, OUTNEURON, PO, RD_LAT, MULT_LAT)) begin : g_illegal
    $error("fc_control_gen: illegal parameter combination");
  end

  fc_state_e             state_q;
  logic [CNT_W-1:0]      c_q, c_d;
  logic [GRP_W-1:0]      g_q, g_d;
  logic                  rden_q, busy_q, done_q;
  logic [IN_ADDR_W-1:0]  addr_a_q, addr_b_q, addr_a_s;
  logic [W_ADDR_W-1:0]   waddr_q, waddr_s;
  logic [META_W-1:0]     meta_q, meta_d, rd_tail_s;
  logic [BANK_W-1:0]     bank_s, rd_bank_s;
  logic                  issue_s, beat_last_s, layer_last_s, last_wr_s;
  logic                  rd_valid_s, rd_first_s, rd_last_s;
  logic [GRP_W-1:0]      rd_g_s;
  logic [WR_W-1:0]       wr_head_s, wr_tail_s;

  // Beat issue decode and counter advance
  always_comb begin
    issue_s      = (state_q == S_ISSUE) && !stall;
    beat_last_s  = (c_q == CNT_W'(STEPS - 1));
    layer_last_s = beat_last_s && (g_q == GRP_W'(GROUPS - 1));
    bank_s       = BANK_W'(int'(c_q) / BPB);
    addr_a_s     = IN_ADDR_W'(32'sd2 * (int'(c_q) % BPB));
    waddr_s      = W_ADDR_W'(int'(g_q) * STEPS + int'(c_q));
    c_d          = c_q;
    g_d          = g_q;
    meta_d       = {META_W{1'b0}};
    if (issue_s) begin
      meta_d = {1'b1, (c_q == {CNT_W{1'b0}}), beat_last_s, bank_s, g_q};
      if (beat_last_s) begin
        c_d = {CNT_W{1'b0}};
        g_d = layer_last_s ? {GRP_W{1'b0}} : g_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end else begin
      meta_d = {META_W{1'b0}};
    end
  end

  // Layer FSM with registered issue strobes and handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      c_q      <= {CNT_W{1'b0}};
      g_q      <= {GRP_W{1'b0}};
      rden_q   <= 1'b0;
      addr_a_q <= {IN_ADDR_W{1'b0}};
      addr_b_q <= {IN_ADDR_W{1'b0}};
      waddr_q  <= {W_ADDR_W{1'b0}};
      meta_q   <= {META_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      g_q      <= g_d;
      rden_q   <= issue_s;
      addr_a_q <= issue_s ? addr_a_s : {IN_ADDR_W{1'b0}};
      addr_b_q <= issue_s ? addr_a_s + 1'b1 : {IN_ADDR_W{1'b0}};
      waddr_q  <= issue_s ? waddr_s : {W_ADDR_W{1'b0}};
      meta_q   <= meta_d;
      busy_q   <= (state_q == S_ISSUE) || (state_q == S_DRAIN);
      done_q   <= (state_q == S_DRAIN) && last_wr_s;
      case (state_q)
        S_IDLE:  if (start) state_q <= S_ISSUE;
        S_ISSUE: if (issue_s && layer_last_s) state_q <= S_DRAIN;
        S_DRAIN: if (last_wr_s) state_q <= S_FIN;
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fc_delay_line #(.DEPTH(RD_LAT), .WIDTH(META_W)) u_rd_align (
    .clk_i (clock),
    .clr_i (reset),
    .d_i   (meta_q),
    .q_o   (rd_tail_s)
  );

  assign {rd_valid_s, rd_first_s, rd_last_s, rd_bank_s, rd_g_s} = rd_tail_s;

  // Bank select on the beat whose read data is arriving now
  always_comb begin
    in_neuron_q_a_mux = {DATA_WIDTH_FC{1'b0}};
    in_neuron_q_b_mux = {DATA_WIDTH_FC{1'b0}};
    for (int p = 0; p < PI; p++) begin
      in_neuron_q_a_mux = (rd_valid_s && (rd_bank_s == BANK_W'(p)))
                          ? in_neuron_q_a_all[p*DATA_WIDTH_FC +: DATA_WIDTH_FC] : in_neuron_q_a_mux;
      in_neuron_q_b_mux = (rd_valid_s && (rd_bank_s == BANK_W'(p)))
                          ? in_neuron_q_b_all[p*DATA_WIDTH_FC +: DATA_WIDTH_FC] : in_neuron_q_b_mux;
    end
  end

  assign wr_head_s = {rd_valid_s & rd_last_s, (rd_valid_s & rd_last_s) ? rd_g_s : {GRP_W{1'b0}}};

  fc_delay_line #(.DEPTH(MULT_LAT), .WIDTH(WR_W)) u_wr_align (
    .clk_i (clock),
    .clr_i (reset),
    .d_i   (wr_head_s),
    .q_o   (wr_tail_s)
  );

  assign write_en         = wr_tail_s[GRP_W];
  assign out_addr         = wr_tail_s[GRP_W-1:0];
  assign last_wr_s        = write_en && (out_addr == GRP_W'(GROUPS - 1));
  assign enable_mult      = rd_valid_s;
  assign accum_sload      = rd_valid_s & rd_first_s;
  assign in_neuron_rden   = rden_q;
  assign fc_weight_rden   = rden_q;
  assign in_neuron_addr_a = addr_a_q;
  assign in_neuron_addr_b = addr_b_q;
  assign fc_weight_addr   = waddr_q;
  assign count_sload      = c_q;
  assign count_out        = g_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
